// File: rtl/rr_hazard_ctrl.sv
// Hazard controller for the 16-bit RR stage. It picks operand forwarding
// sources, sequences load-use stalls, memory-wait freezes and branch flushes,
// and keeps saturating stall/flush event counters.
module rr_hazard_ctrl #(
  parameter int FLUSH_CYCLES    = 2,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rr_valid_i,
  input  logic [2:0]       rr_ra_idx_i,
  input  logic [2:0]       rr_rb_idx_i,
  input  logic             rr_uses_ra_i,
  input  logic             rr_uses_rb_i,
  input  logic             ex_valid_i,
  input  logic [2:0]       ex_rd_idx_i,
  input  logic             ex_is_load_i,
  input  logic             mem_valid_i,
  input  logic [2:0]       mem_rd_idx_i,
  input  logic             wb_valid_i,
  input  logic [2:0]       wb_rd_idx_i,
  input  logic             mem_busy_i,
  input  logic             branch_valid_i,
  output logic             stall_o,
  output logic             bubble_o,
  output logic             freeze_all_o,
  output logic             flush_o,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] LU_RELOAD    = 3'(LOAD_USE_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_next;
  // r_pend: a flush must be (re)started once the memory wait ends.
  // r_pend_new: that flush belongs to a redirect not yet counted.
  logic             r_pend;
  logic             w_pend_next;
  logic             r_pend_new;
  logic             w_pend_new_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_stall;
  logic             w_bubble;
  logic             w_freeze;
  logic             w_flush;
  logic             w_flush_inc;
  logic             w_load_use;
  logic             w_branch;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // Priority forwarding select for one operand; a load in EX has no data yet.
  function automatic logic [1:0] fwd_sel(
    input logic       valid,
    input logic       uses,
    input logic [2:0] idx,
    input logic       exv,
    input logic       exld,
    input logic [2:0] exrd,
    input logic       memv,
    input logic [2:0] memrd,
    input logic       wbv,
    input logic [2:0] wbrd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (valid && uses) begin
      if (exv && !exld && (idx == exrd))  sel = 2'b01;
      else if (memv && (idx == memrd))    sel = 2'b10;
      else if (wbv && (idx == wbrd))      sel = 2'b11;
    end
    return sel;
  endfunction

  // Operand forwarding network, evaluated independently per operand.
  always_comb begin
    w_fwd_a = fwd_sel(rr_valid_i, rr_uses_ra_i, rr_ra_idx_i, ex_valid_i, ex_is_load_i,
                      ex_rd_idx_i, mem_valid_i, mem_rd_idx_i, wb_valid_i, wb_rd_idx_i);
    w_fwd_b = fwd_sel(rr_valid_i, rr_uses_rb_i, rr_rb_idx_i, ex_valid_i, ex_is_load_i,
                      ex_rd_idx_i, mem_valid_i, mem_rd_idx_i, wb_valid_i, wb_rd_idx_i);
  end

  assign w_load_use = rr_valid_i & ex_valid_i & ex_is_load_i &
                      ((rr_uses_ra_i & (rr_ra_idx_i == ex_rd_idx_i)) |
                       (rr_uses_rb_i & (rr_rb_idx_i == ex_rd_idx_i)));

  // A deferred redirect counts as a branch on the first non-busy cycle.
  assign w_branch = branch_valid_i | r_pend;

  // Next-state and control decode: mem_busy > branch > per-state activity.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_pend_next     = r_pend;
    w_pend_new_next = r_pend_new;
    w_stall         = 1'b0;
    w_bubble        = 1'b0;
    w_freeze        = 1'b0;
    w_flush         = 1'b0;
    w_flush_inc     = 1'b0;
    if (mem_busy_i) begin
      // Whole pipeline holds; any stall in progress is re-detected later.
      w_freeze     = 1'b1;
      w_state_next = ST_MEMWAIT;
      if (branch_valid_i) begin
        w_pend_next     = 1'b1;
        w_pend_new_next = 1'b1;
      end
      // An interrupted flush restarts after the wait, without recounting.
      if (r_state == ST_FLUSH) w_pend_next = 1'b1;
    end else if (w_branch) begin
      // Flush kills the RR instruction, so a coincident load-use is moot.
      w_flush         = 1'b1;
      w_flush_inc     = branch_valid_i | r_pend_new;
      w_pend_next     = 1'b0;
      w_pend_new_next = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        w_state_next = ST_FLUSH;
        w_cnt_next   = FLUSH_RELOAD;
      end else begin
        w_state_next = ST_RUN;
      end
    end else begin
      case (r_state)
        ST_FLUSH: begin
          w_flush      = 1'b1;
          w_cnt_next   = r_cnt - 3'd1;
          w_state_next = (r_cnt <= 3'd1) ? ST_RUN : ST_FLUSH;
        end
        ST_LDSTALL: begin
          w_stall      = 1'b1;
          w_bubble     = 1'b1;
          w_cnt_next   = r_cnt - 3'd1;
          w_state_next = (r_cnt <= 3'd1) ? ST_RUN : ST_LDSTALL;
        end
        default: begin
          // RUN, and the first non-busy cycle out of MEMWAIT.
          w_state_next = ST_RUN;
          if (w_load_use) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              w_state_next = ST_LDSTALL;
              w_cnt_next   = LU_RELOAD;
            end
          end
        end
      endcase
    end
  end

  // State, down-counter and pending-redirect registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_RUN;
      r_cnt      <= 3'd0;
      r_pend     <= 1'b0;
      r_pend_new <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_pend     <= w_pend_next;
      r_pend_new <= w_pend_new_next;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // Combinational controls are masked so every output reads 0 during reset.
  assign stall_o      = rst_i & w_stall;
  assign bubble_o     = rst_i & w_bubble;
  assign freeze_all_o = rst_i & w_freeze;
  assign flush_o      = rst_i & w_flush;
  assign fwd_a_sel_o  = rst_i ? w_fwd_a : 2'b00;
  assign fwd_b_sel_o  = rst_i ? w_fwd_b : 2'b00;
  assign state_o      = r_state;
  assign stall_cnt_o  = r_stall_cnt;
  assign flush_cnt_o  = r_flush_cnt;

endmodule

// File: tb/tb_rr_hazard_ctrl.sv
// Directed bench for rr_hazard_ctrl: each step drives inputs on the falling
// edge, queues the expected outputs, and compares them shortly afterwards.
module tb_rr_hazard_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        rr_valid_i, rr_uses_ra_i, rr_uses_rb_i;
  logic [2:0]  rr_ra_idx_i, rr_rb_idx_i;
  logic        ex_valid_i, ex_is_load_i, mem_valid_i, wb_valid_i;
  logic [2:0]  ex_rd_idx_i, mem_rd_idx_i, wb_rd_idx_i;
  logic        mem_busy_i, branch_valid_i;
  logic        stall_o, bubble_o, freeze_all_o, flush_o;
  logic [1:0]  fwd_a_sel_o, fwd_b_sel_o, state_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        stall, bubble, freeze, flush;
    logic [1:0]  fa, fb, st;
    logic [15:0] sc, fc;
  } exp_t;

  exp_t sb_q[$];

  rr_hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_USE_CYCLES(1), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rr_valid_i(rr_valid_i), .rr_ra_idx_i(rr_ra_idx_i), .rr_rb_idx_i(rr_rb_idx_i),
    .rr_uses_ra_i(rr_uses_ra_i), .rr_uses_rb_i(rr_uses_rb_i),
    .ex_valid_i(ex_valid_i), .ex_rd_idx_i(ex_rd_idx_i), .ex_is_load_i(ex_is_load_i),
    .mem_valid_i(mem_valid_i), .mem_rd_idx_i(mem_rd_idx_i),
    .wb_valid_i(wb_valid_i), .wb_rd_idx_i(wb_rd_idx_i),
    .mem_busy_i(mem_busy_i), .branch_valid_i(branch_valid_i),
    .stall_o(stall_o), .bubble_o(bubble_o), .freeze_all_o(freeze_all_o), .flush_o(flush_o),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic drive(input logic rv, input logic [2:0] ra, input logic [2:0] rb,
                       input logic ua, input logic ub,
                       input logic exv, input logic [2:0] exrd, input logic exld,
                       input logic memv, input logic [2:0] memrd,
                       input logic wbv, input logic [2:0] wbrd,
                       input logic busy, input logic br);
    @(negedge clk_i);
    rr_valid_i = rv;  rr_ra_idx_i = ra;  rr_rb_idx_i = rb;
    rr_uses_ra_i = ua; rr_uses_rb_i = ub;
    ex_valid_i = exv; ex_rd_idx_i = exrd; ex_is_load_i = exld;
    mem_valid_i = memv; mem_rd_idx_i = memrd;
    wb_valid_i = wbv; wb_rd_idx_i = wbrd;
    mem_busy_i = busy; branch_valid_i = br;
  endtask

  task automatic idle(input logic busy, input logic br);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, busy, br);
  endtask

  // RR reads r3 (A) while a load to r3 sits in EX.
  task automatic load_use(input logic busy, input logic br);
    drive(1, 3, 0, 1, 0, 1, 3, 1, 0, 0, 0, 0, busy, br);
  endtask

  task automatic expect_out(input string tag, input logic st_o, input logic bu_o,
                            input logic fr_o, input logic fl_o,
                            input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] st,
                            input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    e.tag = tag; e.stall = st_o; e.bubble = bu_o; e.freeze = fr_o; e.flush = fl_o;
    e.fa = fa; e.fb = fb; e.st = st; e.sc = sc; e.fc = fc;
    sb_q.push_back(e);
  endtask

  task automatic cmp(input string tag, input string field,
                     input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp(e.tag, "stall",  16'(stall_o),      16'(e.stall));
      cmp(e.tag, "bubble", 16'(bubble_o),     16'(e.bubble));
      cmp(e.tag, "freeze", 16'(freeze_all_o), 16'(e.freeze));
      cmp(e.tag, "flush",  16'(flush_o),      16'(e.flush));
      cmp(e.tag, "fwd_a",  16'(fwd_a_sel_o),  16'(e.fa));
      cmp(e.tag, "fwd_b",  16'(fwd_b_sel_o),  16'(e.fb));
      cmp(e.tag, "state",  16'(state_o),      16'(e.st));
      cmp(e.tag, "scnt",   stall_cnt_o,       e.sc);
      cmp(e.tag, "fcnt",   flush_cnt_o,       e.fc);
      $display("step %-12s st=%0d stall=%0b flush=%0b freeze=%0b fa=%0d fb=%0d scnt=%0h fcnt=%0h",
               e.tag, state_o, stall_o, flush_o, freeze_all_o, fwd_a_sel_o, fwd_b_sel_o,
               stall_cnt_o, flush_cnt_o);
    end
  endtask

  initial begin
    rst_i = 1'b0;
    rr_valid_i = 0; rr_ra_idx_i = 0; rr_rb_idx_i = 0; rr_uses_ra_i = 0; rr_uses_rb_i = 0;
    ex_valid_i = 0; ex_rd_idx_i = 0; ex_is_load_i = 0; mem_valid_i = 0; mem_rd_idx_i = 0;
    wb_valid_i = 0; wb_rd_idx_i = 0; mem_busy_i = 0; branch_valid_i = 0;

    // In reset, outputs stay 0 even with forwarding/branch/load-use stimulus.
    drive(1, 3, 1, 1, 1, 1, 3, 1, 0, 0, 1, 1, 1, 1);
    expect_out("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0); check_out();

    idle(0, 0); rst_i = 1'b1;
    expect_out("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0); check_out();

    // Forwarding: MEM beats WB for A, B has no producer.
    drive(1, 5, 1, 1, 1, 1, 3, 0, 1, 5, 1, 5, 0, 0);
    expect_out("fwd_mem_wb", 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0); check_out();
    // EX beats MEM.
    drive(1, 3, 5, 1, 1, 1, 3, 0, 1, 5, 1, 5, 0, 0);
    expect_out("fwd_ex", 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0); check_out();
    // Unused source selects regfile.
    drive(1, 3, 5, 0, 1, 1, 3, 0, 1, 5, 0, 0, 0, 0);
    expect_out("fwd_unused", 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0); check_out();
    // Invalid RR instruction selects regfile.
    drive(0, 3, 5, 1, 1, 1, 3, 0, 1, 5, 0, 0, 0, 0);
    expect_out("fwd_rrinv", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0); check_out();
    // WB only for A, MEM for B.
    drive(1, 6, 2, 1, 1, 0, 0, 0, 1, 2, 1, 6, 0, 0);
    expect_out("fwd_wb", 0, 0, 0, 0, 2'b11, 2'b10, 0, 0, 0); check_out();

    // Load-use on B: one bubble, then forward from MEM.
    drive(1, 7, 3, 1, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
    expect_out("ldu_stall", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0); check_out();
    drive(1, 7, 3, 1, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    expect_out("ldu_resume", 0, 0, 0, 0, 2'b00, 2'b10, 0, 1, 0); check_out();
    // Load in EX matching only an unused source: no hazard.
    drive(1, 4, 3, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0);
    expect_out("ldu_unused", 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0); check_out();

    // Branch with coincident load-use: flush wins; second pulse extends.
    load_use(0, 1);
    expect_out("br_t0", 0, 0, 0, 1, 0, 0, 0, 1, 0); check_out();
    idle(0, 1);
    expect_out("br_t1", 0, 0, 0, 1, 0, 0, 3, 1, 1); check_out();
    idle(0, 0);
    expect_out("br_t2", 0, 0, 0, 1, 0, 0, 3, 1, 2); check_out();
    idle(0, 0);
    expect_out("br_done", 0, 0, 0, 0, 0, 0, 0, 1, 2); check_out();

    // Three busy cycles, branch in the second; flush after the wait.
    idle(1, 0);
    expect_out("mw_1", 0, 0, 1, 0, 0, 0, 0, 1, 2); check_out();
    idle(1, 1);
    expect_out("mw_2", 0, 0, 1, 0, 0, 0, 2, 1, 2); check_out();
    idle(1, 0);
    expect_out("mw_3", 0, 0, 1, 0, 0, 0, 2, 1, 2); check_out();
    idle(0, 0);
    expect_out("mw_exit", 0, 0, 0, 1, 0, 0, 2, 1, 2); check_out();
    idle(0, 0);
    expect_out("mw_flush2", 0, 0, 0, 1, 0, 0, 3, 1, 3); check_out();
    idle(0, 0);
    expect_out("mw_run", 0, 0, 0, 0, 0, 0, 0, 1, 3); check_out();

    // mem_busy outranks load-use; the stall is re-detected on resume.
    load_use(1, 0);
    expect_out("busy_ldu", 0, 0, 1, 0, 0, 0, 0, 1, 3); check_out();
    load_use(0, 0);
    expect_out("ldu_after", 1, 1, 0, 0, 0, 0, 2, 1, 3); check_out();
    idle(0, 0);
    expect_out("ldu_cnt", 0, 0, 0, 0, 0, 0, 0, 2, 3); check_out();

    // Busy during FLUSH: flush restarts after the wait, counted once.
    idle(0, 1);
    expect_out("fb_br", 0, 0, 0, 1, 0, 0, 0, 2, 3); check_out();
    idle(1, 0);
    expect_out("fb_busy", 0, 0, 1, 0, 0, 0, 3, 2, 4); check_out();
    idle(0, 0);
    expect_out("fb_restart", 0, 0, 0, 1, 0, 0, 2, 2, 4); check_out();
    idle(0, 0);
    expect_out("fb_flush2", 0, 0, 0, 1, 0, 0, 3, 2, 4); check_out();
    idle(0, 0);
    expect_out("fb_run", 0, 0, 0, 0, 0, 0, 0, 2, 4); check_out();

    // Asynchronous reset in the middle of a flush.
    idle(0, 1);
    expect_out("rf_br", 0, 0, 0, 1, 0, 0, 0, 2, 4); check_out();
    idle(0, 0);
    expect_out("rf_flush", 0, 0, 0, 1, 0, 0, 3, 2, 5); check_out();
    rst_i = 1'b0;
    expect_out("rf_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0); check_out();
    idle(0, 0); rst_i = 1'b1;
    expect_out("rf_release", 0, 0, 0, 0, 0, 0, 0, 0, 0); check_out();

    // Saturation: 65534 load-use cycles, then three more.
    load_use(0, 0);
    repeat (65533) @(negedge clk_i);
    load_use(0, 0);
    expect_out("sat_fffe", 1, 1, 0, 0, 0, 0, 0, 16'hFFFE, 0); check_out();
    for (int i = 0; i < 3; i++) begin
      load_use(0, 0);
      expect_out("sat_ffff", 1, 1, 0, 0, 0, 0, 0, 16'hFFFF, 0); check_out();
    end
    idle(0, 0);
    expect_out("sat_hold", 0, 0, 0, 0, 0, 0, 0, 16'hFFFF, 0); check_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_hazard_ctrl.md
Name: rr_hazard_ctrl

Overview:
- Pipeline hazard controller for the 16-bit register-read (RR) stage and its operand forwarding network.
- Selects the forwarding source for operands A and B from the EX, MEM or WB stage, or the register file.
- Sequences load-use stalls, LSU memory-wait freezes and branch-redirect flushes.
- Keeps saturating stall and flush event counters.
- Sits beside the RR stage, between decode and execute, and drives the front-end freeze, EX bubble and flush controls.

Parameters:
FLUSH_CYCLES, 2, number of cycles flush_o stays high after a branch redirect (1..7)
LOAD_USE_CYCLES, 1, number of bubble cycles inserted per load-use hazard (1..3)
CNT_W, 16, width of the event counters

Ports:
clk_i  in  1  clock; all state changes on the rising edge
rst_i  in  1  asynchronous, active-low reset
rr_valid_i  in  1  RR stage holds a valid instruction
rr_ra_idx_i  in  3  RR source A register index
rr_rb_idx_i  in  3  RR source B register index
rr_uses_ra_i  in  1  instruction in RR reads source A
rr_uses_rb_i  in  1  instruction in RR reads source B
ex_valid_i  in  1  EX stage valid and writes rd
ex_rd_idx_i  in  3  EX destination register index
ex_is_load_i  in  1  instruction in EX is a load
mem_valid_i  in  1  MEM stage valid and writes rd
mem_rd_idx_i  in  3  MEM destination register index
wb_valid_i  in  1  WB stage valid and writes rd
wb_rd_idx_i  in  3  WB destination register index
mem_busy_i  in  1  LSU busy; the whole pipeline must hold
branch_valid_i  in  1  single-cycle pulse: EX resolved a taken branch
stall_o  out  1  freeze PC, IF/ID and ID/RR registers
bubble_o  out  1  force RR->EX valid to 0
freeze_all_o  out  1  freeze every pipeline register (memory wait)
flush_o  out  1  invalidate IF/ID and ID/RR contents
fwd_a_sel_o  out  2  operand A source: 00 regfile, 01 EX, 10 MEM, 11 WB
fwd_b_sel_o  out  2  operand B source, same encoding as operand A
state_o  out  2  FSM state: 0 RUN, 1 LDSTALL, 2 MEMWAIT, 3 FLUSH
stall_cnt_o  out  CNT_W  count of stall_o-high cycles, saturating
flush_cnt_o  out  CNT_W  count of accepted redirects, saturating

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state goes to RUN; all counters, the pending-branch flag and the internal down-counter clear to 0.
  - While in reset, all outputs are 0.
- Forwarding (combinational, evaluated independently for A and B):
  - If the instruction does not use the source, or rr_valid_i=0, the select is 00.
  - Otherwise the first match in this order wins:
    - EX: ex_valid_i & !ex_is_load_i & index match -> 01
    - MEM: mem_valid_i & index match -> 10
    - WB: wb_valid_i & index match -> 11
    - no match -> 00
  - A load in EX never forwards from EX.
- Load-use detect (hazard condition):
  - rr_valid_i & ex_valid_i & ex_is_load_i & ((rr_uses_ra_i & ra==ex_rd) | (rr_uses_rb_i & rb==ex_rd)).
- Priority each cycle: reset > mem_busy_i > branch (new or pending) > load-use.
- State RUN:
  - mem_busy_i: freeze_all_o=1 combinationally; go to MEMWAIT. A branch_valid_i seen in the same cycle sets the pending flag.
  - Branch, no mem_busy_i:
    - flush_o=1 this cycle and flush_cnt increments.
    - FLUSH_CYCLES=1: stay in RUN.
    - FLUSH_CYCLES>1: go to FLUSH with down-counter = FLUSH_CYCLES-1.
    - A load-use condition in the same cycle is ignored, because the flush kills the instruction in RR.
  - Load-use: stall_o=1 and bubble_o=1.
    - LOAD_USE_CYCLES=1: stay in RUN.
    - LOAD_USE_CYCLES>1: go to LDSTALL with down-counter = LOAD_USE_CYCLES-1.
- State LDSTALL:
  - stall_o=1, bubble_o=1; decrement the counter; go to RUN when it reaches 0.
  - mem_busy_i -> MEMWAIT; the remaining stall is abandoned and re-detected on resume.
  - Branch -> flush handling exactly as in RUN.
- State MEMWAIT:
  - freeze_all_o=1, with stall_o=0, bubble_o=0, flush_o=0.
  - branch_valid_i sets the pending flag.
  - Leave on the first cycle mem_busy_i=0: go to RUN, with outputs in that cycle computed as in RUN.
  - A pending branch is serviced in that first cycle (flush_o=1), then the pending flag clears.
- State FLUSH:
  - flush_o=1; decrement the counter; go to RUN when it reaches 0.
  - A new branch reloads the counter to FLUSH_CYCLES-1 and increments flush_cnt.
  - mem_busy_i takes priority: go to MEMWAIT with the pending flag set; the flush restarts after the wait.
- Counters:
  - stall_cnt increments on every cycle with stall_o=1.
  - flush_cnt increments once per redirect serviced.
  - Both saturate at all-ones and do not wrap.
- Outputs other than the fwd selects and the combinational controls are registered; state_o reflects the current state.

Test Plan:
- Reset mid-FLUSH (rst_i low, asynchronous) -> state_o=0, flush_o=0 and both counters 0 immediately, before the next edge.
- RR ADC, ra=5, rb=1; wb_valid=1, wb_rd=5; mem_valid=1, mem_rd=5; ex_valid=1, ex_rd=3 -> fwd_a_sel=10 (MEM beats WB), fwd_b_sel=00, no stall.
- NDZ, ra=7, rb=3; ex_valid=1, ex_rd=3, ex_is_load=1 -> stall_o=bubble_o=1 for 1 cycle; next cycle, with the load now in MEM (mem_rd=3), fwd_b_sel=10; stall_cnt=1.
- branch_valid_i pulse at t, with FLUSH_CYCLES=2 -> flush_o high at t and t+1; state_o sequence 3 then 0; flush_cnt=1. A second pulse at t+1 extends flush_o through t+2; flush_cnt=2.
- mem_busy_i high for 3 cycles with branch_valid_i pulsed in the 2nd cycle -> freeze_all_o=1 for 3 cycles; flush_o=1 on the first non-busy cycle; flush_cnt=1.
- Force stall_cnt to 0xFFFE, then apply 3 load-use cycles -> counter holds at 0xFFFF.
